// File: rtl/capture_writer.sv
// capture_writer: turns strobed 4-channel ADC sets into 4-beat 18-bit PSRAM
// write bursts, with arm/trigger/post-trigger capture into a circular buffer.
// Ports: ad_clk, reset (sync, active-high), psram_ready, ad_a0/a1/b0/b1,
// ad_strobe, arm, trigger, post_count | awaddr/awvalid/awready,
// wdata/wvalid/wready/wlast | busy, done, overflow, trig_addr.
module capture_writer #(
  parameter int DEPTH_LOG2 = 22,
  parameter int FIFO_LOG2  = 4
) (
  input  logic                  ad_clk,
  input  logic                  reset,
  input  logic                  psram_ready,
  input  logic [11:0]           ad_a0,
  input  logic [11:0]           ad_a1,
  input  logic [11:0]           ad_b0,
  input  logic [11:0]           ad_b1,
  input  logic                  ad_strobe,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic [DEPTH_LOG2-1:0] post_count,
  output logic [24:0]           awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [17:0]           wdata,
  output logic                  wvalid,
  input  logic                  wready,
  output logic                  wlast,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [24:0]           trig_addr
);

  localparam int FD = 1 << FIFO_LOG2;

  typedef enum logic [2:0] {
    C_STARTUP, C_IDLE, C_CAPTURE, C_POST, C_DRAIN, C_DONE
  } cst_e;

  typedef enum logic [1:0] {
    W_IDLE, W_ADDR, W_DATA
  } wst_e;

  cst_e                  cst_q, cst_d;
  wst_e                  wst_q;
  logic [DEPTH_LOG2-1:0] push_idx_q, wr_idx_q, post_cnt_q;
  logic                  trig_prev_q, busy_q, done_q, ovf_q;
  logic [24:0]           trig_addr_q, awaddr_q;
  logic [47:0]           mem_q [FD];
  logic [FIFO_LOG2:0]    wp_q, rp_q;
  logic [47:0]           hold_q;
  logic [1:0]            beat_q, beat_nx;
  logic                  awvalid_q, wvalid_q, wlast_q;
  logic [17:0]           wdata_q;
  logic [11:0]           nxt_s;

  logic empty, full, pop, push_req, push, drop;
  logic trig_edge, arm_go;

  // Display path reads {q[12:9], q[7:4]} as the top 8 sample bits.
  function automatic logic [17:0] pack(input logic [11:0] s);
    return {5'b0, s[11:8], 1'b0, s[7:0]};
  endfunction

  assign empty = (wp_q == rp_q);
  assign full  = (wp_q[FIFO_LOG2] != rp_q[FIFO_LOG2]) &&
                 (wp_q[FIFO_LOG2-1:0] == rp_q[FIFO_LOG2-1:0]);
  assign pop   = psram_ready && (wst_q == W_IDLE) && !empty;

  assign push_req = psram_ready && ad_strobe &&
                    ((cst_q == C_CAPTURE) ||
                     ((cst_q == C_POST) && (post_cnt_q != '0)));
  // A same-cycle pop frees a slot, so a full FIFO can still accept.
  assign push = push_req && (!full || pop);
  assign drop = push_req && !push;

  assign trig_edge = psram_ready && ad_strobe && trigger &&
                     !trig_prev_q && (cst_q == C_CAPTURE);
  assign arm_go    = psram_ready && arm &&
                     ((cst_q == C_IDLE) || (cst_q == C_DONE));

  always_comb begin
    cst_d = cst_q;
    unique case (cst_q)
      C_STARTUP: if (psram_ready) cst_d = C_IDLE;
      C_IDLE,
      C_DONE:    if (arm) cst_d = C_CAPTURE;
      C_CAPTURE: if (trig_edge) cst_d = C_POST;
      C_POST:    if (post_cnt_q == '0) cst_d = C_DRAIN;
      C_DRAIN:   if (empty && (wst_q == W_IDLE)) cst_d = C_DONE;
      default:   cst_d = C_STARTUP;
    endcase
    if (!psram_ready) cst_d = C_STARTUP;
  end

  always_ff @(posedge ad_clk) begin
    if (reset) begin
      cst_q       <= C_STARTUP;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      trig_prev_q <= 1'b0;
      push_idx_q  <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
    end else begin
      cst_q  <= cst_d;
      busy_q <= (cst_d == C_CAPTURE) || (cst_d == C_POST) ||
                (cst_d == C_DRAIN);
      if (psram_ready) begin
        if (arm_go) begin
          done_q      <= 1'b0;
          ovf_q       <= 1'b0;
          push_idx_q  <= '0;
          trig_prev_q <= 1'b0;
        end
        if (push) push_idx_q <= push_idx_q + 1'b1;
        if (drop) ovf_q <= 1'b1;
        if ((cst_q == C_CAPTURE) && ad_strobe) trig_prev_q <= trigger;
        // A dropped trigger set points at the slot the next set will take.
        if (trig_edge) begin
          trig_addr_q <= 25'(push_idx_q) << 3;
          post_cnt_q  <= post_count;
        end
        if ((cst_q == C_POST) && (post_cnt_q != '0) && ad_strobe)
          post_cnt_q <= post_cnt_q - 1'b1;
        if ((cst_q == C_DRAIN) && (cst_d == C_DONE)) done_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge ad_clk) begin
    if (push) mem_q[wp_q[FIFO_LOG2-1:0]] <= {ad_b1, ad_b0, ad_a1, ad_a0};
  end

  always_comb begin
    beat_nx = beat_q + 2'd1;
    case (beat_nx)
      2'd1:    nxt_s = hold_q[23:12];
      2'd2:    nxt_s = hold_q[35:24];
      2'd3:    nxt_s = hold_q[47:36];
      default: nxt_s = hold_q[11:0];
    endcase
  end

  always_ff @(posedge ad_clk) begin
    if (reset) begin
      wst_q     <= W_IDLE;
      wp_q      <= '0;
      rp_q      <= '0;
      wr_idx_q  <= '0;
      hold_q    <= '0;
      beat_q    <= '0;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
      wlast_q   <= 1'b0;
    end else if (!psram_ready) begin
      wst_q     <= W_IDLE;
      wp_q      <= '0;
      rp_q      <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      unique case (wst_q)
        W_IDLE: if (pop) begin
          hold_q    <= mem_q[rp_q[FIFO_LOG2-1:0]];
          rp_q      <= rp_q + 1'b1;
          wst_q     <= W_ADDR;
          awvalid_q <= 1'b1;
          awaddr_q  <= 25'(wr_idx_q) << 3;
        end
        W_ADDR: if (awready) begin
          awvalid_q <= 1'b0;
          wst_q     <= W_DATA;
          beat_q    <= 2'd0;
          wvalid_q  <= 1'b1;
          wdata_q   <= pack(hold_q[11:0]);
          wlast_q   <= 1'b0;
        end
        W_DATA: if (wready) begin
          if (beat_q == 2'd3) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
            wr_idx_q <= wr_idx_q + 1'b1;
            wst_q    <= W_IDLE;
          end else begin
            beat_q  <= beat_nx;
            wdata_q <= pack(nxt_s);
            wlast_q <= (beat_nx == 2'd3);
          end
        end
        default: wst_q <= W_IDLE;
      endcase
      if (arm_go) wr_idx_q <= '0;
    end
  end

  assign awaddr    = awaddr_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wvalid    = wvalid_q;
  assign wlast     = wlast_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign trig_addr = trig_addr_q;

endmodule

// File: tb/tb_capture_writer.sv
// Bench for capture_writer (DEPTH_LOG2=4): scoreboard of expected bursts
// against bursts collected from the write channel.
module tb_capture_writer;

  localparam int DL = 4;

  logic          ad_clk = 1'b0;
  logic          reset = 1'b1;
  logic          psram_ready = 1'b0;
  logic [11:0]   ad_a0 = '0, ad_a1 = '0, ad_b0 = '0, ad_b1 = '0;
  logic          ad_strobe = 1'b0;
  logic          arm = 1'b0;
  logic          trigger = 1'b0;
  logic [DL-1:0] post_count = '0;
  logic [24:0]   awaddr;
  logic          awvalid;
  logic          awready = 1'b1;
  logic [17:0]   wdata;
  logic          wvalid;
  logic          wready = 1'b1;
  logic          wlast;
  logic          busy, done, overflow;
  logic [24:0]   trig_addr;

  capture_writer #(.DEPTH_LOG2(DL), .FIFO_LOG2(4)) u_dut (
    .ad_clk(ad_clk), .reset(reset), .psram_ready(psram_ready),
    .ad_a0(ad_a0), .ad_a1(ad_a1), .ad_b0(ad_b0), .ad_b1(ad_b1),
    .ad_strobe(ad_strobe), .arm(arm), .trigger(trigger),
    .post_count(post_count),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
    .busy(busy), .done(done), .overflow(overflow), .trig_addr(trig_addr)
  );

  always #5 ad_clk = ~ad_clk;

  typedef struct packed {
    logic [24:0] addr;
    logic [71:0] data;
    logic        wl_ok;
    logic [7:0]  wcyc;
  } burst_t;

  burst_t exp_q[$];
  burst_t obs_q[$];
  int passed = 0;
  int total = 0;
  int overlap_err = 0;
  int stab_err = 0;

  burst_t      cur;
  int          m_beat = 0;
  logic        in_b = 1'b0, wstall = 1'b0, astall = 1'b0;
  logic [17:0] pw = '0;
  logic [24:0] pa = '0;

  always @(negedge ad_clk) begin
    if (reset || !psram_ready) begin
      in_b = 1'b0; wstall = 1'b0; astall = 1'b0;
    end else begin
      if (awvalid && wvalid) overlap_err++;
      if (astall && awvalid && awaddr !== pa) stab_err++;
      if (wstall && wvalid && wdata !== pw) stab_err++;
      astall = awvalid && !awready; pa = awaddr;
      wstall = wvalid && !wready; pw = wdata;
      if (awvalid && awready) begin
        cur.addr = awaddr; cur.data = '0; cur.wl_ok = 1'b1;
        cur.wcyc = 8'd0; m_beat = 0; in_b = 1'b1;
      end else if (wvalid && in_b) begin
        cur.wcyc = cur.wcyc + 8'd1;
        if (wlast !== (m_beat == 3)) cur.wl_ok = 1'b0;
        if (wready) begin
          cur.data[m_beat*18 +: 18] = wdata;
          if (m_beat == 3) begin
            obs_q.push_back(cur); in_b = 1'b0;
          end
          m_beat++;
        end
      end
    end
  end

  function automatic logic [17:0] pk(input logic [11:0] s);
    return {5'b0, s[11:8], 1'b0, s[7:0]};
  endfunction

  function automatic burst_t mk(input int idx, input logic [11:0] a0,
                                input logic [11:0] a1, input logic [11:0] b0,
                                input logic [11:0] b1);
    burst_t b;
    b.addr  = 25'((idx % (1 << DL)) * 8);
    b.data  = {pk(b1), pk(b0), pk(a1), pk(a0)};
    b.wl_ok = 1'b1;
    b.wcyc  = 8'd4;
    return b;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ad_clk); #1;
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(1); arm = 1'b0;
  endtask

  task automatic strobe(input logic [11:0] a0, input logic [11:0] a1,
                        input logic [11:0] b0, input logic [11:0] b1,
                        input logic trg, input int gap);
    ad_a0 = a0; ad_a1 = a1; ad_b0 = b0; ad_b1 = b1;
    trigger = trg; ad_strobe = 1'b1;
    tick(1);
    ad_strobe = 1'b0; trigger = 1'b0;
    tick(gap - 1);
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (obs_q.size() >= n) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (done) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; psram_ready = 1'b0;
    tick(3);
    total++; if ({awvalid, wvalid, wlast} !== 3'b000)
      $display("FAIL reset_valid: got %b want 000", {awvalid, wvalid, wlast});
    else passed++;
    total++; if ({busy, done, overflow} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {busy, done, overflow});
    else passed++;
    total++; if (awaddr !== 25'h0 || wdata !== 18'h0 || trig_addr !== 25'h0)
      $display("FAIL reset_data: awaddr %h wdata %h trig %h want 0",
               awaddr, wdata, trig_addr);
    else passed++;
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_basic();
    burst_t e, o;
    bit ok;
    psram_ready = 1'b1;
    tick(3);
    pulse_arm();
    total++; if (busy !== 1'b1)
      $display("FAIL basic_busy: got %b want 1", busy);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(mk(i, 12'hABC, 12'(12'h123 + i), 12'h456, 12'hF0F));
      strobe(12'hABC, 12'(12'h123 + i), 12'h456, 12'hF0F, 1'b0, 8);
    end
    wait_obs(3, 100, ok);
    total++; if (!ok)
      $display("FAIL basic_count: got %0d bursts want 3", obs_q.size());
    else passed++;
    for (int i = 0; i < 3; i++) begin
      if (obs_q.size() == 0) break;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.addr !== e.addr)
        $display("FAIL basic_addr%0d: got %h want %h", i, o.addr, e.addr);
      else passed++;
      total++; if (o.data !== e.data)
        $display("FAIL basic_data%0d: got %h want %h", i, o.data, e.data);
      else passed++;
      total++; if (o.wl_ok !== 1'b1 || o.wcyc !== 8'd4)
        $display("FAIL basic_wlast%0d: wl_ok %b wcyc %0d want 1/4",
                 i, o.wl_ok, o.wcyc);
      else passed++;
      if (i == 0) begin
        total++; if (o.data[17:0] !== 18'h014BC)
          $display("FAIL basic_beat0: got %h want 014bc", o.data[17:0]);
        else passed++;
      end
    end
    total++; if (overflow !== 1'b0)
      $display("FAIL basic_ovf: got %b want 0", overflow);
    else passed++;
  endtask

  task automatic restart();
    psram_ready = 1'b0; tick(1);
    psram_ready = 1'b1; tick(2);
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_trigger();
    burst_t e, o;
    bit ok;
    restart();
    post_count = 4'd2;
    pulse_arm();
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(mk(i, 12'(i * 17), 12'(i + 5), 12'h800, 12'(12'hFFF - i)));
      strobe(12'(i * 17), 12'(i + 5), 12'h800, 12'(12'hFFF - i), i >= 4, 8);
    end
    wait_done(200, ok);
    total++; if (!ok || busy !== 1'b0)
      $display("FAIL trig_done: done %b busy %b want 1/0", done, busy);
    else passed++;
    total++; if (trig_addr !== 25'h20)
      $display("FAIL trig_addr: got %h want 20", trig_addr);
    else passed++;
    total++; if (obs_q.size() != 7)
      $display("FAIL trig_count: got %0d want 7", obs_q.size());
    else passed++;
    for (int i = 0; i < 7; i++) begin
      if (obs_q.size() == 0) break;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.addr !== e.addr || o.data !== e.data)
        $display("FAIL trig_burst%0d: got %h/%h want %h/%h",
                 i, o.addr, o.data, e.addr, e.data);
      else passed++;
    end
    for (int i = 0; i < 3; i++) strobe(12'h111, 12'h222, 12'h333, 12'h444, 1'b1, 8);
    tick(40);
    total++; if (obs_q.size() != 0 || done !== 1'b1)
      $display("FAIL trig_after: bursts %0d done %b want 0/1", obs_q.size(), done);
    else passed++;
  endtask

  task automatic test_overflow();
    burst_t e, o;
    bit ok;
    exp_q.delete(); obs_q.delete();
    pulse_arm();
    total++; if (done !== 1'b0 || overflow !== 1'b0)
      $display("FAIL ovf_arm: done %b ovf %b want 0/0", done, overflow);
    else passed++;
    awready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i < 17)
        exp_q.push_back(mk(i, 12'(i * 3 + 1), 12'(i + 12'h100), 12'(i * 7), 12'h5A5));
      strobe(12'(i * 3 + 1), 12'(i + 12'h100), 12'(i * 7), 12'h5A5, 1'b0, 4);
    end
    total++; if (overflow !== 1'b1)
      $display("FAIL ovf_flag: got %b want 1", overflow);
    else passed++;
    awready = 1'b1;
    wait_obs(17, 300, ok);
    total++; if (!ok)
      $display("FAIL ovf_count: got %0d bursts want 17", obs_q.size());
    else passed++;
    for (int i = 0; i < 17; i++) begin
      if (obs_q.size() == 0) break;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.addr !== e.addr || o.data !== e.data)
        $display("FAIL ovf_burst%0d: got %h/%h want %h/%h",
                 i, o.addr, o.data, e.addr, e.data);
      else passed++;
    end
    tick(30);
    total++; if (obs_q.size() != 0)
      $display("FAIL ovf_extra: got %0d bursts want 0", obs_q.size());
    else passed++;
    psram_ready = 1'b0; tick(1);
    total++; if (overflow !== 1'b1 || awvalid !== 1'b0 || busy !== 1'b0)
      $display("FAIL ovf_hold: ovf %b awvalid %b busy %b want 1/0/0",
               overflow, awvalid, busy);
    else passed++;
    psram_ready = 1'b1; tick(2);
  endtask

  task automatic test_wrap();
    burst_t e, o;
    bit ok;
    exp_q.delete(); obs_q.delete();
    post_count = 4'd0;
    pulse_arm();
    total++; if (overflow !== 1'b0)
      $display("FAIL wrap_ovf_clr: got %b want 0", overflow);
    else passed++;
    for (int i = 0; i < 19; i++) begin
      exp_q.push_back(mk(i, 12'(i), 12'(i << 4), 12'(i << 8), 12'hC3C));
      strobe(12'(i), 12'(i << 4), 12'(i << 8), 12'hC3C, i == 18, 8);
    end
    wait_done(200, ok);
    total++; if (!ok)
      $display("FAIL wrap_done: got %b want 1", done);
    else passed++;
    total++; if (trig_addr !== 25'h10)
      $display("FAIL wrap_trig: got %h want 10", trig_addr);
    else passed++;
    total++; if (obs_q.size() != 19)
      $display("FAIL wrap_count: got %0d want 19", obs_q.size());
    else passed++;
    for (int i = 0; i < 19; i++) begin
      if (obs_q.size() == 0) break;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.addr !== e.addr || o.data !== e.data)
        $display("FAIL wrap_burst%0d: got %h/%h want %h/%h",
                 i, o.addr, o.data, e.addr, e.data);
      else passed++;
    end
  endtask

  task automatic test_wready_toggle();
    burst_t e, o;
    bit started;
    exp_q.delete(); obs_q.delete();
    pulse_arm();
    wready = 1'b0;
    started = 1'b0;
    exp_q.push_back(mk(0, 12'h9A5, 12'h3C7, 12'hE18, 12'h06F));
    strobe(12'h9A5, 12'h3C7, 12'hE18, 12'h06F, 1'b0, 1);
    for (int c = 0; c < 60; c++) begin
      tick(1);
      if (obs_q.size() >= 1) break;
      if (started) wready = ~wready;
      else if (wvalid) started = 1'b1;
    end
    wready = 1'b1;
    total++; if (obs_q.size() != 1)
      $display("FAIL wrdy_count: got %0d want 1", obs_q.size());
    else passed++;
    if (obs_q.size() != 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.addr !== e.addr || o.data !== e.data || o.wl_ok !== 1'b1)
        $display("FAIL wrdy_burst: got %h/%h/%b want %h/%h/1",
                 o.addr, o.data, o.wl_ok, e.addr, e.data);
      else passed++;
      total++; if (o.wcyc !== 8'd8)
        $display("FAIL wrdy_cycles: got %0d want 8", o.wcyc);
      else passed++;
    end
  endtask

  task automatic test_ready_drop();
    burst_t e, o;
    bit seen, ok;
    pulse_arm();
    seen = 1'b0;
    strobe(12'h777, 12'h888, 12'h999, 12'hAAA, 1'b0, 1);
    for (int c = 0; c < 40; c++) begin
      tick(1);
      if (wvalid) begin seen = 1'b1; break; end
    end
    total++; if (!seen || awaddr !== 25'h8)
      $display("FAIL drop_pre: seen %b awaddr %h want 1/8", seen, awaddr);
    else passed++;
    psram_ready = 1'b0; tick(1);
    total++; if ({awvalid, wvalid, wlast, busy} !== 4'b0000)
      $display("FAIL drop_out: got %b want 0000", {awvalid, wvalid, wlast, busy});
    else passed++;
    total++; if (trig_addr !== 25'h10)
      $display("FAIL drop_trig_hold: got %h want 10", trig_addr);
    else passed++;
    exp_q.delete(); obs_q.delete();
    psram_ready = 1'b1; tick(2);
    pulse_arm();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(mk(i, 12'(12'h321 + i), 12'h654, 12'h987, 12'hCBA));
      strobe(12'(12'h321 + i), 12'h654, 12'h987, 12'hCBA, 1'b0, 8);
    end
    wait_obs(2, 60, ok);
    total++; if (!ok)
      $display("FAIL drop_count: got %0d want 2", obs_q.size());
    else passed++;
    for (int i = 0; i < 2; i++) begin
      if (obs_q.size() == 0) break;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      total++; if (o.addr !== e.addr || o.data !== e.data)
        $display("FAIL drop_burst%0d: got %h/%h want %h/%h",
                 i, o.addr, o.data, e.addr, e.data);
      else passed++;
    end
  endtask

  task automatic test_protocol();
    total++; if (overlap_err != 0)
      $display("FAIL proto_overlap: got %0d want 0", overlap_err);
    else passed++;
    total++; if (stab_err != 0)
      $display("FAIL proto_stable: got %0d want 0", stab_err);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trigger();
    test_overflow();
    test_wrap();
    test_wready_toggle();
    test_ready_drop();
    test_protocol();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
